pipeline_hazard_ctrl: RTL and testbench

Central load/flush sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register in the pipelined RV32IMC core. It drives the per-register load and flush controls from four sources: load-use hazards, taken branches/jumps, data-memory wait states, and the multi-cycle DIV/REM unit. It holds the divide-busy state machine and a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the sequencer, load/flush controls back out.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        ex_div_start;
  logic        mem_stall;

  logic        pc_load;
  logic        ifid_load;
  logic        idex_load;
  logic        exmem_load;
  logic        memwb_load;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cycles;

  // The pipeline datapath drives status and consumes controls.
  modport master (
    output id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, ex_div_start, mem_stall,
    input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, ex_div_start, mem_stall,
    output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load/flush sequencer for the pipeline registers and PC, with the divide-busy FSM
// and a saturating count of cycles in which the PC did not advance.
module pipeline_hazard_ctrl #(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        stall_cnt;
  logic               lu;
  logic               cnt_zero;
  logic               div_freeze;
  logic               release_cyc;
  logic               pc_load_w;

  assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
              ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
  assign cnt_zero    = (cnt == '0);
  assign div_freeze  = ((state == IDLE) && hz.ex_div_start) ||
                       ((state == BUSY) && !cnt_zero) ||
                       ((state == BUSY) && cnt_zero && hz.mem_stall);
  assign release_cyc = (state == BUSY) && cnt_zero && !hz.mem_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start seen in BUSY belongs to the same frozen DIV and never restarts the countdown.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hz.ex_div_start && !hz.mem_stall) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(DIV_LATENCY - 1);
        end
      end
      BUSY: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (!hz.mem_stall) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pc_load_w      = 1'b1;
    hz.ifid_load   = 1'b1;
    hz.idex_load   = 1'b1;
    hz.exmem_load  = 1'b1;
    hz.memwb_load  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    if (hz.mem_stall) begin
      pc_load_w     = 1'b0;
      hz.ifid_load  = 1'b0;
      hz.idex_load  = 1'b0;
      hz.exmem_load = 1'b0;
      hz.memwb_load = 1'b0;
    end else if (div_freeze) begin
      pc_load_w      = 1'b0;
      hz.ifid_load   = 1'b0;
      hz.idex_load   = 1'b0;
      hz.exmem_flush = 1'b1;
    end else if (release_cyc) begin
      // Release cycle lets the DIV result through untouched; branch/LU re-evaluate next cycle.
      pc_load_w = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (lu) begin
      pc_load_w     = 1'b0;
      hz.ifid_load  = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  assign hz.pc_load      = pc_load_w;
  assign hz.md_busy      = (state == BUSY);
  assign hz.md_done      = release_cyc;
  assign hz.stall_cycles = stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!pc_load_w && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DIV_LATENCY=4): expected control vectors are
// queued as each step is driven and popped when the combinational outputs settle.
module tb_pipeline_hazard_ctrl;

  localparam int DIV_LATENCY = 4;
  localparam int CNT_W       = 3;

  // Vector order: pc ifid idex exmem memwb | ifid_f idex_f exmem_f | busy done
  localparam logic [9:0] NORMAL   = 10'b11111_000_00;
  localparam logic [9:0] MSTALL   = 10'b00000_000_00;
  localparam logic [9:0] MSTALLBZ = 10'b00000_000_10;
  localparam logic [9:0] DIVSTART = 10'b00011_001_00;
  localparam logic [9:0] DIVBUSY  = 10'b00011_001_10;
  localparam logic [9:0] RELEASE  = 10'b11111_000_11;
  localparam logic [9:0] BRANCH   = 10'b11111_110_00;
  localparam logic [9:0] LUSTALL  = 10'b00111_010_00;

  logic clk;
  logic reset;
  int   compareCount;
  int   failCount;

  logic [9:0] expq[$];
  string      tagq[$];

  pipeline_hazard_ctrl_if bif ();

  pipeline_hazard_ctrl #(
    .DIV_LATENCY(DIV_LATENCY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    logic [9:0] exp;
    logic [9:0] obs;
    string      tag;
    compareCount++;
    obs = {bif.pc_load, bif.ifid_load, bif.idex_load, bif.exmem_load, bif.memwb_load,
           bif.ifid_flush, bif.idex_flush, bif.exmem_flush, bif.md_busy, bif.md_done};
    if (expq.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%b expected=<queued entry>", obs);
    end else begin
      exp = expq.pop_front();
      tag = tagq.pop_front();
      assert (obs === exp) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic checkCount(input logic [31:0] exp, input string tag);
    compareCount++;
    assert (bif.stall_cycles === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, bif.stall_cycles, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic mr, input logic [4:0] rd, input logic br,
                               input logic dv, input logic ms, input logic [9:0] exp,
                               input string tag);
    @(negedge clk);
    reset               = rstv;
    bif.id_rs1          = rs1;
    bif.id_rs2          = rs2;
    bif.ex_mem_read     = mr;
    bif.ex_rd           = rd;
    bif.ex_branch_taken = br;
    bif.ex_div_start    = dv;
    bif.mem_stall       = ms;
    expq.push_back(exp);
    tagq.push_back(tag);
    #1;
    checkOutput();
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    reset               = 1'b0;
    bif.id_rs1          = '0;
    bif.id_rs2          = '0;
    bif.ex_mem_read     = 1'b0;
    bif.ex_rd           = '0;
    bif.ex_branch_taken = 1'b0;
    bif.ex_div_start    = 1'b0;
    bif.mem_stall       = 1'b0;

    // Reset held with random register fields and no active control sources
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)), 1'b0,
                    5'($urandom_range(31)), 1'b0, 1'b0, 1'b0, NORMAL, "reset_outputs");
    end
    checkCount(32'd0, "reset_stall_count");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL, "idle_after_reset");
    end
    checkCount(32'd0, "idle_stall_count");

    // Load-use via rs2, then rs1, then the x0 exemption
    applyStimulus(1'b1, 5'd7, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LUSTALL, "lu_rs2");
    applyStimulus(1'b1, 5'd7, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, NORMAL, "lu_rs2_after");
    checkCount(32'd1, "lu_stall_count");
    applyStimulus(1'b1, 5'd9, 5'd4, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LUSTALL, "lu_rs1");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORMAL, "lu_x0");
    applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NORMAL, "load_no_match");
    checkCount(32'd2, "lu_x0_count");

    // Divide with start held through the release cycle
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVSTART, "div_c0");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVBUSY,  "div_c1");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVBUSY,  "div_c2");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVBUSY,  "div_c3");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, RELEASE,  "div_c4_release");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL,   "div_no_restart");
    checkCount(32'd6, "div_stall_count");

    // Divide with mem_stall in cycles 3-5; branch and LU inside the freeze are ignored
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVSTART, "divms_c0");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, DIVBUSY,  "divms_c1_branch");
    applyStimulus(1'b1, 5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, DIVBUSY,  "divms_c2_lu");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, MSTALLBZ, "divms_c3");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, MSTALLBZ, "divms_c4");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, MSTALLBZ, "divms_c5");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, RELEASE,  "divms_c6_release");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL,   "divms_after");
    checkCount(32'd12, "divms_stall_count");

    // Branch beats a simultaneous load-use hazard; then a plain memory stall
    applyStimulus(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, BRANCH, "branch_over_lu");
    checkCount(32'd12, "branch_no_stall");
    applyStimulus(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, MSTALL, "mem_stall_top");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL, "mem_stall_after");
    checkCount(32'd13, "mem_stall_count");

    // Reset asserted in cycle 2 of a divide aborts it asynchronously
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVSTART, "rstdiv_c0");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DIVBUSY,  "rstdiv_c1");
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL,   "rstdiv_abort");
    checkCount(32'd0, "rstdiv_count_cleared");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, NORMAL, "rstdiv_no_done");
    end
    checkCount(32'd0, "rstdiv_final_count");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
